// File: rtl/sym_upsampler.sv
// QPSK symbol upsampler: a small symbol FIFO feeding an OSR-phase output stream with stall support.
// Fill samples are sample-and-hold by default; define ZERO_STUFF_EN to emit zeros on phases 1..OSR-1.
module sym_upsampler #(
  parameter int OSR        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  I_in,
  input  logic [1:0]  Q_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  I_out,
  output logic [1:0]  Q_out,
  output logic        sym_start,
  input  logic        clr_status,
  output logic        underrun,
  output logic        bad_sym,
  output logic [15:0] sym_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(OSR);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_phase;
  logic [1:0]    r_sym_i;
  logic [1:0]    r_sym_q;
  logic          r_underrun;
  logic          r_bad_sym;
  logic [15:0]   r_sym_cnt;

  logic w_fifo_empty;
  logic w_push;
  logic w_pop;
  logic w_xfer;
  logic w_last;
  logic w_underrun_evt;
  logic w_bad_evt;

  // Pop decisions look only at the pre-edge count, so a symbol written this edge is never bypassed.
  assign w_fifo_empty   = (r_count == '0);
  assign in_ready       = (r_count < DEPTH_C);
  assign w_push         = in_valid && in_ready;
  assign w_xfer         = (r_state == RUN) && out_ready;
  assign w_last         = (r_phase == LAST_PHASE);
  assign w_pop          = !w_fifo_empty && ((r_state == IDLE) || (w_xfer && w_last));
  assign w_underrun_evt = w_xfer && w_last && w_fifo_empty;
  assign w_bad_evt      = w_push && (!I_in[0] || !Q_in[0]);

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {I_in, Q_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty)  w_next_state = RUN;
      RUN:     if (w_underrun_evt) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == RUN);
    sym_start = (r_state == RUN) && (r_phase == '0);
    I_out     = 2'b00;
    Q_out     = 2'b00;
    if (r_state == RUN) begin
      if (r_phase == '0) begin
        I_out = r_sym_i;
        Q_out = r_sym_q;
      end else begin
`ifdef ZERO_STUFF_EN
        I_out = 2'b00;
        Q_out = 2'b00;
`else
        I_out = r_sym_i;
        Q_out = r_sym_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_sym_i    <= 2'b00;
      r_sym_q    <= 2'b00;
      r_underrun <= 1'b0;
      r_bad_sym  <= 1'b0;
      r_sym_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_phase            <= '0;
        {r_sym_i, r_sym_q} <= r_mem[r_rd_ptr];
      end else if (w_xfer) begin
        r_phase <= w_last ? '0 : r_phase + PW'(1);
      end
      // A set event on the same edge as clr_status wins.
      r_underrun <= w_underrun_evt ? 1'b1 : (clr_status ? 1'b0 : r_underrun);
      r_bad_sym  <= w_bad_evt      ? 1'b1 : (clr_status ? 1'b0 : r_bad_sym);
      r_sym_cnt  <= r_sym_cnt + {15'b0, w_pop};
    end
  end

  assign underrun = r_underrun;
  assign bad_sym  = r_bad_sym;
  assign sym_cnt  = r_sym_cnt;

endmodule

// File: tb/tb_sym_upsampler.sv
// Self-checking bench for sym_upsampler: directed scenarios plus random traffic against a queue-based model.
// Honours ZERO_STUFF_EN the same way the design does.
module tb_sym_upsampler;

  localparam int OSR        = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef ZERO_STUFF_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  I_in;
  logic [1:0]  Q_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  I_out;
  logic [1:0]  Q_out;
  logic        sym_start;
  logic        clr_status;
  logic        underrun;
  logic        bad_sym;
  logic [15:0] sym_cnt;

  sym_upsampler #(.OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .I_in       (I_in),
    .Q_in       (Q_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .I_out      (I_out),
    .Q_out      (Q_out),
    .sym_start  (sym_start),
    .clr_status (clr_status),
    .underrun   (underrun),
    .bad_sym    (bad_sym),
    .sym_cnt    (sym_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: symbol queue, busy flag, phase index and sticky flags.
  logic [3:0]  m_q[$];
  bit          m_busy;
  int          m_phase;
  logic [1:0]  m_sym_i;
  logic [1:0]  m_sym_q;
  logic [15:0] m_cnt;
  bit          m_und;
  bit          m_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy  = 1'b0;
    m_phase = 0;
    m_sym_i = 2'b00;
    m_sym_q = 2'b00;
    m_cnt   = 16'h0000;
    m_und   = 1'b0;
    m_bad   = 1'b0;
  endtask

  task automatic model_edge(input logic iv, input logic [1:0] ii, input logic [1:0] iq,
                            input logic ordy, input logic clr);
    int         occ;
    bit         push;
    bit         do_pop;
    bit         und_evt;
    bit         bad_evt;
    logic [3:0] s;
    occ     = m_q.size();
    push    = iv && (occ < FIFO_DEPTH);
    do_pop  = 1'b0;
    und_evt = 1'b0;
    if (m_busy) begin
      if (ordy) begin
        if (m_phase == OSR - 1) begin
          if (occ > 0) do_pop = 1'b1;
          else begin
            m_busy  = 1'b0;
            und_evt = 1'b1;
          end
          m_phase = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end else if (occ > 0) begin
      do_pop  = 1'b1;
      m_busy  = 1'b1;
      m_phase = 0;
    end
    if (do_pop) begin
      s       = m_q.pop_front();
      m_sym_i = s[3:2];
      m_sym_q = s[1:0];
      m_cnt   = m_cnt + 16'd1;
    end
    if (push) m_q.push_back({ii, iq});
    bad_evt = push && (ii == 2'b00 || ii == 2'b10 || iq == 2'b00 || iq == 2'b10);
    m_und   = und_evt ? 1'b1 : (clr ? 1'b0 : m_und);
    m_bad   = bad_evt ? 1'b1 : (clr ? 1'b0 : m_bad);
  endtask

  task automatic compare_all();
    logic [1:0] ei;
    logic [1:0] eq;
    ei = 2'b00;
    eq = 2'b00;
    if (m_busy && (m_phase == 0 || !ZS)) begin
      ei = m_sym_i;
      eq = m_sym_q;
    end
    check("in_ready",  in_ready,  (m_q.size() < FIFO_DEPTH));
    check("out_valid", out_valid, m_busy);
    check("sym_start", sym_start, m_busy && m_phase == 0);
    check("I_out",     I_out,     ei);
    check("Q_out",     Q_out,     eq);
    check("underrun",  underrun,  m_und);
    check("bad_sym",   bad_sym,   m_bad);
    check("sym_cnt",   sym_cnt,   m_cnt);
  endtask

  // Drive at a falling edge, let the rising edge act, then compare at the next falling edge.
  task automatic cycle(input logic iv, input logic [1:0] ii, input logic [1:0] iq,
                       input logic ordy, input logic clr);
    in_valid   = iv;
    I_in       = ii;
    Q_in       = iq;
    out_ready  = ordy;
    clr_status = clr;
    @(posedge clk);
    model_edge(iv, ii, iq, ordy, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, 2'b00, 2'b00, ordy, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clr_status = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    I_in       = 2'b00;
    Q_in       = 2'b00;
    out_ready  = 1'b0;
    clr_status = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Single symbol, sample stream, return to idle with underrun.
    cycle(1'b1, 2'b01, 2'b11, 1'b1, 1'b0);
    check("lat_after_accept", out_valid, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    check("lat_two_clocks", out_valid, 1'b1);
    check("first_sym_start", sym_start, 1'b1);
    idle(7, 1'b1);
    check("single_underrun", underrun, 1'b1);
    check("single_cnt", sym_cnt, 16'd1);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b1);

    // Back-to-back symbols fill the FIFO and stream without gaps.
    for (int k = 0; k < 5; k++) cycle(1'b1, 2'b01, (k % 2 == 0) ? 2'b01 : 2'b11, 1'b1, 1'b0);
    idle(25, 1'b1);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b1);

    // Stalls while streaming.
    cycle(1'b1, 2'b11, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) cycle(1'b0, 2'b00, 2'b00, (k % 2 == 0), 1'b0);
    idle(4, 1'b1);

    // Sticky bad-symbol flag and clear priority.
    cycle(1'b1, 2'b10, 2'b01, 1'b1, 1'b0);
    check("bad_set", bad_sym, 1'b1);
    idle(2, 1'b1);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    check("bad_clr", bad_sym, 1'b0);
    cycle(1'b1, 2'b00, 2'b11, 1'b1, 1'b1);
    check("bad_set_wins", bad_sym, 1'b1);
    idle(10, 1'b1);

    // Reset at phase 2 with three symbols queued.
    apply_reset();
    cycle(1'b1, 2'b01, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 2'b01, 1'b0, 1'b0);
    idle(2, 1'b1);
    check("pre_reset_busy", out_valid, 1'b1);
    apply_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    idle(8, 1'b1);

    // Counter wrap: hold the counter at 0xFFFF across an edge with no pop, then pop once.
    force dut.r_sym_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_sym_cnt;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    compare_all();
    cycle(1'b1, 2'b01, 2'b01, 1'b1, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    check("cnt_wrap", sym_cnt, 16'h0000);
    idle(6, 1'b1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 9) < 6), 2'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    idle(30, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sym_upsampler.md
SYM_UPSAMPLER -- requirements
Module: sym_upsampler

Interface
REQ-001 Parameter OSR, default 4, samples per symbol; legal range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 4, symbol FIFO entries; power of two, 2..16.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  upstream symbol on I_in/Q_in is valid.
REQ-006 Port in_ready  output  1  FIFO can accept a symbol; high exactly when FIFO count < FIFO_DEPTH.
REQ-007 Port I_in, Q_in  input  2 each  QPSK mapper symbol, 2-bit two's complement: 01 = +1, 11 = -1.
REQ-008 Port out_valid  output  1  sample on I_out/Q_out is valid.
REQ-009 Port out_ready  input  1  downstream accepts the current sample.
REQ-010 Port I_out, Q_out  output  2 each  upsampled sample, same encoding as inputs; 00 = zero.
REQ-011 Port sym_start  output  1  high when out_valid is high and phase = 0.
REQ-012 Port clr_status  input  1  synchronous clear of underrun and bad_sym.
REQ-013 Port underrun  output  1  sticky: the stream ran dry after starting.
REQ-014 Port bad_sym  output  1  sticky: an accepted symbol had I or Q equal to 00 or 10.
REQ-015 Port sym_cnt  output  16  count of symbols popped from the FIFO; wraps 0xFFFF -> 0x0000.

Function
REQ-016 A symbol is accepted on a rising edge where in_valid && in_ready; it is written to the FIFO tail; data order is preserved.
REQ-017 No bypass: a pop reads only entries present before the current edge; a write and a pop on the same edge leave the count unchanged.
REQ-018 States: IDLE (out_valid = 0) and RUN (out_valid = 1); phase counter 0..OSR-1.
REQ-019 IDLE -> RUN on any edge with FIFO count > 0: pop head into the symbol register, phase = 0, sym_cnt += 1.
REQ-020 Latency: a symbol accepted into an empty FIFO while IDLE is presented with out_valid = 1 after the second following edge (2 clocks).
REQ-021 In RUN a sample transfers on an edge with out_ready = 1; phase advances only on a transfer; out_ready = 0 holds all outputs stable.
REQ-022 Transfer at phase OSR-1 with FIFO non-empty: pop the next symbol, phase = 0, stay in RUN, no bubble.
REQ-023 Transfer at phase OSR-1 with FIFO empty: go to IDLE and set underrun.
REQ-024 Output at phase 0 is the symbol register; phases 1..OSR-1 are defined in REQ-033/034.
REQ-025 bad_sym sets when an accepted symbol has I_in or Q_in equal to 00 or 10; the symbol is passed through unmodified.
REQ-026 clr_status clears underrun and bad_sym; a set event on the same edge wins.

Reset
REQ-027 While rst_n = 0 the block is in IDLE, FIFO count 0, and phase 0.
REQ-028 While rst_n = 0, out_valid, sym_start, underrun, bad_sym, sym_cnt, I_out and Q_out are all 0.
REQ-029 in_ready = 1 from reset onward because the FIFO is empty.
REQ-030 Reset asserted mid-symbol discards the FIFO and the current symbol immediately, with no completion of remaining phases.

Configuration
REQ-031 Macro ZERO_STUFF_EN selects the fill samples.
REQ-032 The fill selection is the only compile-time option.
REQ-033 With ZERO_STUFF_EN defined, phases 1..OSR-1 output I_out = Q_out = 00.
REQ-034 Without ZERO_STUFF_EN, phases 1..OSR-1 repeat the symbol register (sample-and-hold).

Verification
REQ-035 Reset, then one symbol I=01,Q=11 with out_ready=1 -> out_valid high 2 clocks after acceptance, 4 samples (01/11 x4 hold; 01/11 then 00/00 x3 with ZERO_STUFF_EN), sym_start on first, then IDLE, underrun=1.
REQ-036 Five back-to-back symbols, out_ready=1 -> in_ready drops at count 4; 20 contiguous samples with no gap; sym_cnt=5; underrun set only after the last sample.
REQ-037 out_ready toggled 1,0,1,0 during a symbol -> phase advances only on ready cycles; outputs stable while stalled; still exactly 4 samples per symbol.
REQ-038 Symbol I=10 accepted -> bad_sym=1; clr_status pulse -> bad_sym=0; clr_status coincident with a new bad symbol -> bad_sym stays 1.
REQ-039 rst_n pulled low at phase 2 with 3 symbols queued -> outputs 0 immediately; after release, in_ready=1 and no stale samples appear.
REQ-040 Force sym_cnt to 0xFFFF, then pop one symbol -> sym_cnt=0x0000.
